// File: rtl/lc3_fetch.sv
// LC-3 fetch stage: owns the PC and keeps one imem read in flight.
// Define LC3_FETCH_PERF_EN to enable the delivery/squash counters.
module lc3_fetch #(
  parameter logic [15:0] RESET_PC = 16'h3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_fetch,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] taddr,
  input  logic        imem_valid,
  input  logic [15:0] Imem_dout,
  output logic        instrmem_rd,
  output logic [15:0] imem_addr,
  output logic [15:0] instr_out,
  output logic [15:0] npc_out,
  output logic        enable_decode,
  output logic [15:0] pc,
  output logic [15:0] perf_delivered,
  output logic [15:0] perf_squashed
);

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        squash;
  logic [15:0] hold;
  logic [15:0] pc_inc;

  logic redirect;
  logic deliver;
  logic use_hold;
  logic drop;
  logic load_hold;
  logic set_sq;
  logic clr_sq;

  assign imem_addr = pc;
  assign pc_inc    = pc + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) state <= S_ISSUE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_ISSUE: begin
        if (enable_fetch && !br_taken) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (br_taken) begin
          if (imem_valid) state_nx = S_ISSUE;
        end else if (imem_valid) begin
          if (squash || !stall) state_nx = S_ISSUE;
          else                  state_nx = S_HOLD;
        end
      end
      S_HOLD: begin
        if (br_taken || !stall) state_nx = S_ISSUE;
      end
      default: state_nx = S_ISSUE;
    endcase
  end

  always_comb begin
    instrmem_rd = 1'b0;
    redirect    = 1'b0;
    deliver     = 1'b0;
    use_hold    = 1'b0;
    drop        = 1'b0;
    load_hold   = 1'b0;
    set_sq      = 1'b0;
    clr_sq      = 1'b0;
    unique case (state)
      S_ISSUE: begin
        instrmem_rd = enable_fetch & ~br_taken;
        redirect    = br_taken;
      end
      S_WAIT: begin
        if (br_taken) begin
          redirect = 1'b1;
          // a response in the same cycle is already stale
          if (imem_valid) begin
            drop   = 1'b1;
            clr_sq = 1'b1;
          end else begin
            set_sq = 1'b1;
          end
        end else if (imem_valid) begin
          if (squash) begin
            drop   = 1'b1;
            clr_sq = 1'b1;
          end else if (!stall) begin
            deliver = 1'b1;
          end else begin
            load_hold = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (br_taken) begin
          redirect = 1'b1;
          drop     = 1'b1;
        end else if (!stall) begin
          deliver  = 1'b1;
          use_hold = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_PC;
      instr_out     <= 16'h0000;
      npc_out       <= 16'h0000;
      enable_decode <= 1'b0;
      squash        <= 1'b0;
      hold          <= 16'h0000;
    end else begin
      enable_decode <= deliver;
      if (redirect) begin
        pc <= taddr;
      end else if (deliver) begin
        pc        <= pc_inc;
        npc_out   <= pc_inc;
        instr_out <= use_hold ? hold : Imem_dout;
      end
      if (clr_sq)      squash <= 1'b0;
      else if (set_sq) squash <= 1'b1;
      if (load_hold)   hold <= Imem_dout;
      else if (drop)   hold <= 16'h0000;
    end
  end

`ifdef LC3_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_delivered <= 16'h0000;
      perf_squashed  <= 16'h0000;
    end else begin
      if (deliver) perf_delivered <= perf_delivered + 16'd1;
      if (drop)    perf_squashed  <= perf_squashed + 16'd1;
    end
  end
`else
  assign perf_delivered = 16'h0000;
  assign perf_squashed  = 16'h0000;
`endif

endmodule
